// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing-bus pipeline: default field widths,
// the idle bus value and the maximum supported delay.
package vga_pkg;

    localparam int HCOUNT_W  = 11;
    localparam int VCOUNT_W  = 11;
    localparam int RGB_W     = 12;
    localparam int MAX_DEPTH = 16;

    localparam logic IDLE_SYNC = 1'b0;
    localparam logic IDLE_BLNK = 1'b1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
    } vga_strobes_t;

    localparam vga_strobes_t IDLE_STROBES = '{
        hsync: IDLE_SYNC,
        vsync: IDLE_SYNC,
        hblnk: IDLE_BLNK,
        vblnk: IDLE_BLNK
    };

endpackage

// File: rtl/vga_shreg.sv
// Generic WIDTH x DEPTH shift register with enable; every stage resets to
// RST_VAL asynchronously.
module vga_shreg #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $fatal(1, "vga_shreg: DEPTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_bus_delay.sv
// Delays the VGA timing bus by DEPTH enabled cycles and rgb by DEPTH-RGB_LAG,
// with frame counter and lock flag. Define VGA_DELAY_BLANK_MASK_EN to zero rgb in blanking.
module vga_bus_delay #(
    parameter int HC_W    = vga_pkg::HCOUNT_W,
    parameter int VC_W    = vga_pkg::VCOUNT_W,
    parameter int RGB_W   = vga_pkg::RGB_W,
    parameter int DEPTH   = 2,
    parameter int RGB_LAG = 0,
    parameter int FC_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [HC_W-1:0]  in_hcount,
    input  logic [VC_W-1:0]  in_vcount,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_hblnk,
    input  logic             in_vblnk,
    input  logic [RGB_W-1:0] in_rgb,
    output logic [HC_W-1:0]  out_hcount,
    output logic [VC_W-1:0]  out_vcount,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_hblnk,
    output logic             out_vblnk,
    output logic [RGB_W-1:0] out_rgb,
    output logic [FC_W-1:0]  frame_cnt,
    output logic             locked
);

    localparam int RGB_DEPTH = DEPTH - RGB_LAG;
    localparam int CTRL_W    = HC_W + VC_W + 4;
    localparam int FILL_W    = $clog2(vga_pkg::MAX_DEPTH + 1);
    localparam logic [CTRL_W-1:0] CTRL_IDLE = {{(HC_W + VC_W){1'b0}}, vga_pkg::IDLE_STROBES};

    generate
        if (DEPTH < 1 || DEPTH > vga_pkg::MAX_DEPTH || RGB_LAG < 0 || RGB_LAG > DEPTH) begin : g_bad_params
            $fatal(1, "vga_bus_delay: illegal DEPTH/RGB_LAG combination");
        end
    endgenerate

    logic [CTRL_W-1:0]     ctrl_in;
    logic [CTRL_W-1:0]     ctrl_dly;
    logic [CTRL_W-1:0]     ctrl_sel;
    logic [RGB_W-1:0]      rgb_dly;
    logic [RGB_W-1:0]      rgb_sel;
    vga_pkg::vga_strobes_t strobes;

    logic [FILL_W-1:0] fill_q, fill_d;
    logic              filled;
    logic              vsync_prev_q, vsync_prev_d;
    logic              vsync_rise;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              seen_rise_q, seen_rise_d;
    logic              locked_q, locked_d;

    assign ctrl_in = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk};

    vga_shreg #(
        .WIDTH   (CTRL_W),
        .DEPTH   (DEPTH),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_shreg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .din  (ctrl_in),
        .dout (ctrl_dly)
    );

    // Input rgb that already lags by DEPTH cycles needs no register at all.
    generate
        if (RGB_DEPTH == 0) begin : g_rgb_bypass
            assign rgb_dly = in_rgb;
        end else begin : g_rgb_shreg
            vga_shreg #(
                .WIDTH   (RGB_W),
                .DEPTH   (RGB_DEPTH),
                .RST_VAL ('0)
            ) u_rgb_shreg (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .din  (in_rgb),
                .dout (rgb_dly)
            );
        end
    endgenerate

    // The shorter rgb path fills early, so both paths are masked until the control path is full.
    assign filled = (fill_q == FILL_W'(DEPTH));

    always_comb begin
        ctrl_sel = filled ? ctrl_dly : CTRL_IDLE;
        rgb_sel  = filled ? rgb_dly  : '0;
    end

    assign {out_hcount, out_vcount, strobes} = ctrl_sel;
    assign out_hsync = strobes.hsync;
    assign out_vsync = strobes.vsync;
    assign out_hblnk = strobes.hblnk;
    assign out_vblnk = strobes.vblnk;

`ifdef VGA_DELAY_BLANK_MASK_EN
    assign out_rgb = (strobes.hblnk || strobes.vblnk) ? '0 : rgb_sel;
`else
    assign out_rgb = rgb_sel;
`endif

    always_comb begin
        fill_d       = (en && !filled) ? fill_q + 1'b1 : fill_q;
        vsync_rise   = en && out_vsync && !vsync_prev_q;
        vsync_prev_d = en ? out_vsync : vsync_prev_q;
        frame_cnt_d  = vsync_rise ? frame_cnt_q + 1'b1 : frame_cnt_q;
        seen_rise_d  = seen_rise_q | vsync_rise;
        locked_d     = locked_q | (vsync_rise & seen_rise_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            vsync_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
            seen_rise_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            vsync_prev_q <= vsync_prev_d;
            frame_cnt_q  <= frame_cnt_d;
            seen_rise_q  <= seen_rise_d;
            locked_q     <= locked_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign locked    = locked_q;

endmodule
